// File: rtl/ysyx_23060025_axi_sram_slave.sv
// AXI4 single-beat SRAM responder with programmable read/write latency.
// Independent read and write engines, one outstanding transaction per channel.
module ysyx_23060025_axi_sram_slave #(
  parameter int unsigned          ADDR_LEN   = 32,
  parameter logic [ADDR_LEN-1:0]  BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned          DEPTH_LOG2 = 10,
  parameter int unsigned          R_LATENCY  = 2,
  parameter int unsigned          W_LATENCY  = 2
) (
  input  logic                clock,
  input  logic                reset,
  // read address channel
  input  logic [ADDR_LEN-1:0] s_ar_addr_i,
  input  logic                s_ar_valid_i,
  output logic                s_ar_ready_o,
  input  logic [3:0]          s_ar_id_i,
  input  logic [7:0]          s_ar_len_i,
  // read data channel
  output logic [31:0]         s_r_data_o,
  output logic [1:0]          s_r_resp_o,
  output logic                s_r_valid_o,
  input  logic                s_r_ready_i,
  output logic                s_r_last_o,
  output logic [3:0]          s_r_id_o,
  // write address channel
  input  logic [ADDR_LEN-1:0] s_aw_addr_i,
  input  logic                s_aw_valid_i,
  output logic                s_aw_ready_o,
  input  logic [3:0]          s_aw_id_i,
  input  logic [7:0]          s_aw_len_i,
  // write data channel
  input  logic [31:0]         s_w_data_i,
  input  logic [3:0]          s_w_strb_i,
  input  logic                s_w_valid_i,
  output logic                s_w_ready_o,
  // write response channel
  output logic [1:0]          s_b_resp_o,
  output logic                s_b_valid_o,
  input  logic                s_b_ready_i,
  output logic [3:0]          s_b_id_o
);

  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam int unsigned TAG_LO = DEPTH_LOG2 + 2;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned IDX_W  = DEPTH_LOG2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_e;

  // Bursts are rejected first; otherwise the upper address bits must match the window.
  function automatic logic [1:0] resp_of(input logic [ADDR_LEN-1:0] addr,
                                         input logic [7:0]          len);
    if (len != 8'd0) return RESP_SLVERR;
    if (addr[ADDR_LEN-1:TAG_LO] != BASE_ADDR[ADDR_LEN-1:TAG_LO]) return RESP_DECERR;
    return RESP_OKAY;
  endfunction

  logic [31:0] mem [DEPTH];

  // read engine state
  r_state_e          r_state_q, r_state_d;
  logic              ar_ready_q, ar_ready_d;
  logic              r_valid_q, r_valid_d;
  logic              r_last_q, r_last_d;
  logic [31:0]       r_data_q, r_data_d;
  logic [1:0]        r_resp_q, r_resp_d;
  logic [3:0]        r_id_q, r_id_d;
  logic [CNT_W-1:0]  r_cnt_q, r_cnt_d;
  logic [IDX_W-1:0]  r_idx_q, r_idx_d;

  // write engine state
  w_state_e          w_state_q, w_state_d;
  logic              aw_ready_q, aw_ready_d;
  logic              w_ready_q, w_ready_d;
  logic              aw_got_q, aw_got_d;
  logic              w_got_q, w_got_d;
  logic              b_valid_q, b_valid_d;
  logic [1:0]        b_resp_q, b_resp_d;
  logic [3:0]        b_id_q, b_id_d;
  logic [CNT_W-1:0]  w_cnt_q, w_cnt_d;
  logic [IDX_W-1:0]  w_idx_q, w_idx_d;
  logic [31:0]       w_data_q, w_data_d;
  logic [3:0]        w_strb_q, w_strb_d;
  logic              aw_hs, w_hs;
  logic              mem_we;

  // Byte-offset address bits carry no information for full-word accesses.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{s_ar_addr_i[1:0], s_aw_addr_i[1:0]};

  // Read engine next-state and registered-output values.
  always_comb begin
    r_state_d  = r_state_q;
    r_data_d   = r_data_q;
    r_resp_d   = r_resp_q;
    r_id_d     = r_id_q;
    r_cnt_d    = r_cnt_q;
    r_idx_d    = r_idx_q;
    ar_ready_d = 1'b0;
    r_valid_d  = 1'b0;
    r_last_d   = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        if (ar_ready_q && s_ar_valid_i) begin
          r_state_d = R_WAIT;
          r_cnt_d   = CNT_W'(R_LATENCY);
          r_idx_d   = s_ar_addr_i[TAG_LO-1:2];
          r_id_d    = s_ar_id_i;
          r_resp_d  = resp_of(s_ar_addr_i, s_ar_len_i);
        end
      end
      R_WAIT: begin
        if (r_cnt_q == '0) begin
          r_state_d = R_RESP;
          r_data_d  = (r_resp_q == RESP_OKAY) ? mem[r_idx_q] : 32'd0;
        end else begin
          r_cnt_d = r_cnt_q - CNT_W'(1);
        end
      end
      R_RESP: begin
        if (s_r_ready_i) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
    ar_ready_d = (r_state_d == R_IDLE);
    r_valid_d  = (r_state_d == R_RESP);
    r_last_d   = (r_state_d == R_RESP);
  end

  // Read engine registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state_q  <= R_IDLE;
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      r_last_q   <= 1'b0;
      r_data_q   <= '0;
      r_resp_q   <= '0;
      r_id_q     <= '0;
      r_cnt_q    <= '0;
      r_idx_q    <= '0;
    end else begin
      r_state_q  <= r_state_d;
      ar_ready_q <= ar_ready_d;
      r_valid_q  <= r_valid_d;
      r_last_q   <= r_last_d;
      r_data_q   <= r_data_d;
      r_resp_q   <= r_resp_d;
      r_id_q     <= r_id_d;
      r_cnt_q    <= r_cnt_d;
      r_idx_q    <= r_idx_d;
    end
  end

  // Write engine next-state; AW and W may arrive in either order or together.
  always_comb begin
    w_state_d  = w_state_q;
    aw_got_d   = aw_got_q;
    w_got_d    = w_got_q;
    b_resp_d   = b_resp_q;
    b_id_d     = b_id_q;
    w_cnt_d    = w_cnt_q;
    w_idx_d    = w_idx_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    aw_hs      = 1'b0;
    w_hs       = 1'b0;
    mem_we     = 1'b0;
    aw_ready_d = 1'b0;
    w_ready_d  = 1'b0;
    b_valid_d  = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        aw_hs = aw_ready_q && s_aw_valid_i;
        w_hs  = w_ready_q && s_w_valid_i;
        if (aw_hs) begin
          aw_got_d = 1'b1;
          w_idx_d  = s_aw_addr_i[TAG_LO-1:2];
          b_id_d   = s_aw_id_i;
          b_resp_d = resp_of(s_aw_addr_i, s_aw_len_i);
        end
        if (w_hs) begin
          w_got_d  = 1'b1;
          w_data_d = s_w_data_i;
          w_strb_d = s_w_strb_i;
        end
        if (aw_got_d && w_got_d) begin
          w_state_d = W_WAIT;
          w_cnt_d   = CNT_W'(W_LATENCY);
          aw_got_d  = 1'b0;
          w_got_d   = 1'b0;
        end
      end
      W_WAIT: begin
        if (w_cnt_q == '0) begin
          w_state_d = W_RESP;
          mem_we    = (b_resp_q == RESP_OKAY);
        end else begin
          w_cnt_d = w_cnt_q - CNT_W'(1);
        end
      end
      W_RESP: begin
        if (s_b_ready_i) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    aw_ready_d = (w_state_d == W_IDLE) && !aw_got_d;
    w_ready_d  = (w_state_d == W_IDLE) && !w_got_d;
    b_valid_d  = (w_state_d == W_RESP);
  end

  // Write engine registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      w_state_q  <= W_IDLE;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= '0;
      b_id_q     <= '0;
      w_cnt_q    <= '0;
      w_idx_q    <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
    end else begin
      w_state_q  <= w_state_d;
      aw_ready_q <= aw_ready_d;
      w_ready_q  <= w_ready_d;
      aw_got_q   <= aw_got_d;
      w_got_q    <= w_got_d;
      b_valid_q  <= b_valid_d;
      b_resp_q   <= b_resp_d;
      b_id_q     <= b_id_d;
      w_cnt_q    <= w_cnt_d;
      w_idx_q    <= w_idx_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
    end
  end

  // SRAM byte-strobed commit; contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_strb_q[b]) mem[w_idx_q][8*b +: 8] <= w_data_q[8*b +: 8];
      end
    end
  end

  assign s_ar_ready_o = ar_ready_q;
  assign s_r_data_o   = r_data_q;
  assign s_r_resp_o   = r_resp_q;
  assign s_r_valid_o  = r_valid_q;
  assign s_r_last_o   = r_last_q;
  assign s_r_id_o     = r_id_q;
  assign s_aw_ready_o = aw_ready_q;
  assign s_w_ready_o  = w_ready_q;
  assign s_b_resp_o   = b_resp_q;
  assign s_b_valid_o  = b_valid_q;
  assign s_b_id_o     = b_id_q;

endmodule

// File: tb/tb_ysyx_23060025_axi_sram_slave.sv
// Bench for the AXI SRAM responder: instance 0 uses latency 2/2, instance 1 uses 0/0.
module tb_ysyx_23060025_axi_sram_slave;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] WIN  = 32'h0000_1000;

  logic clk;
  logic rst_n;

  logic [31:0] ar_addr [2];
  logic        ar_valid[2];
  logic        ar_ready[2];
  logic [3:0]  ar_id   [2];
  logic [7:0]  ar_len  [2];
  logic [31:0] r_data  [2];
  logic [1:0]  r_resp  [2];
  logic        r_valid [2];
  logic        r_ready [2];
  logic        r_last  [2];
  logic [3:0]  r_id    [2];
  logic [31:0] aw_addr [2];
  logic        aw_valid[2];
  logic        aw_ready[2];
  logic [3:0]  aw_id   [2];
  logic [7:0]  aw_len  [2];
  logic [31:0] w_data  [2];
  logic [3:0]  w_strb  [2];
  logic        w_valid [2];
  logic        w_ready [2];
  logic [1:0]  b_resp  [2];
  logic        b_valid [2];
  logic        b_ready [2];
  logic [3:0]  b_id    [2];

  logic [31:0] mdl [2][1024];
  int total;
  int bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ysyx_23060025_axi_sram_slave #(
      .R_LATENCY((g == 0) ? 2 : 0),
      .W_LATENCY((g == 0) ? 2 : 0)
    ) u_dut (
      .clock(clk), .reset(rst_n),
      .s_ar_addr_i(ar_addr[g]), .s_ar_valid_i(ar_valid[g]), .s_ar_ready_o(ar_ready[g]),
      .s_ar_id_i(ar_id[g]), .s_ar_len_i(ar_len[g]),
      .s_r_data_o(r_data[g]), .s_r_resp_o(r_resp[g]), .s_r_valid_o(r_valid[g]),
      .s_r_ready_i(r_ready[g]), .s_r_last_o(r_last[g]), .s_r_id_o(r_id[g]),
      .s_aw_addr_i(aw_addr[g]), .s_aw_valid_i(aw_valid[g]), .s_aw_ready_o(aw_ready[g]),
      .s_aw_id_i(aw_id[g]), .s_aw_len_i(aw_len[g]),
      .s_w_data_i(w_data[g]), .s_w_strb_i(w_strb[g]), .s_w_valid_i(w_valid[g]),
      .s_w_ready_o(w_ready[g]),
      .s_b_resp_o(b_resp[g]), .s_b_valid_o(b_valid[g]), .s_b_ready_i(b_ready[g]),
      .s_b_id_o(b_id[g])
    );
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  // Reference decode: bursts are SLVERR, anything outside the 4 KiB window is DECERR.
  function automatic logic [1:0] exp_resp(input logic [31:0] a, input logic [7:0] len);
    if (len != 8'd0) return 2'b10;
    if (a < BASE || a >= BASE + WIN) return 2'b11;
    return 2'b00;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  task automatic do_read(input int k, input logic [31:0] addr, input logic [3:0] id,
                         input logic [7:0] len, input int hold, output logic [31:0] got);
    logic [1:0]  er;
    logic [31:0] ed;
    int n;
    er = exp_resp(addr, len);
    ed = (er == 2'b00) ? mdl[k][idx_of(addr)] : 32'd0;
    ar_addr[k] = addr; ar_id[k] = id; ar_len[k] = len; ar_valid[k] = 1'b1;
    n = 0;
    while (!ar_ready[k] && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) check("ar_ready_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
    ar_valid[k] = 1'b0;
    check("ar_ready_drop", 64'(ar_ready[k]), 64'(0));
    n = 0;
    while (!r_valid[k] && n < 40) begin @(posedge clk); #1; n++; end
    check("r_latency", 64'(n), 64'(1 + lat_of(k)));
    check("r_payload", {r_data[k], r_resp[k], r_id[k], r_last[k]}, {ed, er, id, 1'b1});
    got = r_data[k];
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("r_hold", {r_valid[k], ar_ready[k], r_data[k], r_resp[k], r_id[k]},
            {1'b1, 1'b0, ed, er, id});
    end
    r_ready[k] = 1'b1;
    @(posedge clk); #1;
    r_ready[k] = 1'b0;
    check("r_done", {r_valid[k], ar_ready[k]}, 2'b01);
  endtask

  task automatic do_write(input int k, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [3:0] id, input logic [7:0] len,
                          input int order, input int gap, input int hold);
    logic [1:0] er;
    int n;
    er = exp_resp(addr, len);
    aw_addr[k] = addr; aw_id[k] = id; aw_len[k] = len;
    w_data[k] = data; w_strb[k] = strb;
    if (order == 0) begin
      aw_valid[k] = 1'b1; w_valid[k] = 1'b1;
      n = 0;
      while (!(aw_ready[k] && w_ready[k]) && n < 50) begin @(posedge clk); #1; n++; end
      if (n >= 50) check("aww_timeout", 64'(0), 64'(1));
      @(posedge clk); #1;
      aw_valid[k] = 1'b0; w_valid[k] = 1'b0;
    end else begin
      if (order == 1) w_valid[k] = 1'b1; else aw_valid[k] = 1'b1;
      n = 0;
      while (!((order == 1) ? w_ready[k] : aw_ready[k]) && n < 50) begin
        @(posedge clk); #1; n++;
      end
      if (n >= 50) check("first_timeout", 64'(0), 64'(1));
      @(posedge clk); #1;
      aw_valid[k] = 1'b0; w_valid[k] = 1'b0;
      for (int i = 0; i < gap; i++) begin
        check("w_gap", {aw_ready[k], w_ready[k], b_valid[k]},
              (order == 1) ? 3'b100 : 3'b010);
        @(posedge clk); #1;
      end
      if (order == 1) aw_valid[k] = 1'b1; else w_valid[k] = 1'b1;
      n = 0;
      while (!((order == 1) ? aw_ready[k] : w_ready[k]) && n < 50) begin
        @(posedge clk); #1; n++;
      end
      if (n >= 50) check("second_timeout", 64'(0), 64'(1));
      @(posedge clk); #1;
      aw_valid[k] = 1'b0; w_valid[k] = 1'b0;
    end
    check("w_accepted", {aw_ready[k], w_ready[k]}, 2'b00);
    n = 0;
    while (!b_valid[k] && n < 40) begin @(posedge clk); #1; n++; end
    check("b_latency", 64'(n), 64'(1 + lat_of(k)));
    check("b_payload", {b_resp[k], b_id[k]}, {er, id});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("b_hold", {b_valid[k], aw_ready[k], w_ready[k], b_resp[k], b_id[k]},
            {3'b100, er, id});
    end
    b_ready[k] = 1'b1;
    @(posedge clk); #1;
    b_ready[k] = 1'b0;
    check("b_done", {b_valid[k], aw_ready[k], w_ready[k]}, 3'b011);
    if (er == 2'b00) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) mdl[k][idx_of(addr)][8*b +: 8] = data[8*b +: 8];
    end
  endtask

  function automatic logic [31:0] pick_addr(input int sel);
    int idx;
    idx = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 7)) : 1016 + int'($urandom_range(0, 7));
    if (sel == 0) return BASE + WIN + 32'(idx * 4);
    return BASE + 32'(idx * 4) + 32'($urandom_range(0, 3));
  endfunction

  initial begin : main
    logic [31:0] rd;
    logic [31:0] rd2;
    logic [31:0] a;
    int k;
    total = 0;
    bad = 0;
    for (int i = 0; i < 2; i++) begin
      ar_addr[i] = '0; ar_valid[i] = 1'b0; ar_id[i] = '0; ar_len[i] = '0; r_ready[i] = 1'b0;
      aw_addr[i] = '0; aw_valid[i] = 1'b0; aw_id[i] = '0; aw_len[i] = '0;
      w_data[i] = '0; w_strb[i] = '0; w_valid[i] = 1'b0; b_ready[i] = 1'b0;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("reset_ctrl", {ar_ready[i], r_valid[i], r_last[i], r_resp[i], r_id[i],
                           aw_ready[i], w_ready[i], b_valid[i], b_resp[i], b_id[i]}, 64'(0));
      check("reset_rdata", 64'(r_data[i]), 64'(0));
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", {ar_ready[0], aw_ready[0], w_ready[0]}, 3'b111);

    // basic write then read on the latency-2 instance
    do_write(0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 4'd3, 8'd0, 0, 0, 0);
    do_read(0, 32'h8000_0010, 4'd5, 8'd0, 0, rd);
    check("basic_rd", 64'(rd), 64'(32'hDEAD_BEEF));

    // strobe merge
    do_write(0, 32'h8000_0020, 32'h1122_3344, 4'hF, 4'd1, 8'd0, 0, 0, 0);
    do_write(0, 32'h8000_0020, 32'h0000_AA00, 4'h2, 4'd2, 8'd0, 0, 0, 0);
    do_read(0, 32'h8000_0020, 4'd6, 8'd0, 0, rd);
    check("strb_merge", 64'(rd), 64'(32'h1122_AA44));

    // out-of-window and burst errors; dropped writes leave SRAM alone
    do_read(0, 32'h1000_0000, 4'd7, 8'd0, 0, rd);
    do_write(0, 32'h1000_0010, 32'h5555_5555, 4'hF, 4'd8, 8'd0, 0, 0, 0);
    do_write(0, 32'h8000_1010, 32'h6666_6666, 4'hF, 4'd9, 8'd0, 0, 0, 0);
    do_read(0, 32'h8000_0010, 4'd1, 8'd3, 0, rd);
    do_write(0, 32'h8000_0010, 32'h7777_7777, 4'hF, 4'd4, 8'd1, 0, 0, 0);
    do_read(0, 32'h8000_0010, 4'd2, 8'd0, 0, rd);
    check("miss_no_write", 64'(rd), 64'(32'hDEAD_BEEF));

    // W leads AW by 4 cycles; responses back-pressured for 5 cycles
    do_write(0, 32'h8000_0030, 32'hA5A5_0F0F, 4'hF, 4'd11, 8'd0, 1, 4, 5);
    do_read(0, 32'h8000_0030, 4'd12, 8'd0, 5, rd);

    // zero-latency instance, then same-index read and write in the same cycle
    do_write(1, 32'h8000_0100, 32'hCAFE_0001, 4'hF, 4'd3, 8'd0, 0, 0, 0);
    do_read(1, 32'h8000_0100, 4'd4, 8'd0, 0, rd);
    fork
      do_read(1, 32'h8000_0100, 4'd5, 8'd0, 0, rd);
      do_write(1, 32'h8000_0100, 32'hCAFE_0002, 4'hF, 4'd6, 8'd0, 0, 0, 0);
    join
    check("same_cycle_old", 64'(rd), 64'(32'hCAFE_0001));
    do_read(1, 32'h8000_0100, 4'd7, 8'd0, 0, rd2);
    check("same_cycle_new", 64'(rd2), 64'(32'hCAFE_0002));

    // reset dropped while both engines wait
    do_write(0, 32'h8000_0040, 32'h0BAD_F00D, 4'hF, 4'd9, 8'd0, 0, 0, 0);
    do_read(0, 32'h8000_0040, 4'd9, 8'd0, 0, rd);
    ar_addr[0] = 32'h8000_0040; ar_id[0] = 4'd10; ar_len[0] = 8'd0; ar_valid[0] = 1'b1;
    aw_addr[0] = 32'h8000_0040; aw_id[0] = 4'd10; aw_len[0] = 8'd0; aw_valid[0] = 1'b1;
    w_data[0] = 32'hFFFF_FFFF; w_strb[0] = 4'hF; w_valid[0] = 1'b1;
    @(posedge clk); #1;
    ar_valid[0] = 1'b0; aw_valid[0] = 1'b0; w_valid[0] = 1'b0;
    check("pre_reset_busy", {ar_ready[0], aw_ready[0], w_ready[0], r_valid[0], b_valid[0]}, 5'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midreset_ctrl", {ar_ready[0], r_valid[0], r_last[0], r_resp[0], r_id[0],
                            aw_ready[0], w_ready[0], b_valid[0], b_resp[0], b_id[0]}, 64'(0));
    check("midreset_rdata", 64'(r_data[0]), 64'(0));
    #2;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("no_resp_after_reset", {r_valid[0], b_valid[0]}, 2'b00);
    end
    check("ready_back", {ar_ready[0], aw_ready[0], w_ready[0]}, 3'b111);
    do_read(0, 32'h8000_0040, 4'd3, 8'd0, 0, rd);
    check("aborted_write", 64'(rd), 64'(32'h0BAD_F00D));

    // random phase: seed every word the random addresses can reach
    for (int kk = 0; kk < 2; kk++) begin
      for (int j = 0; j < 16; j++) begin
        a = BASE + 32'(((j < 8) ? j : 1008 + j) * 4);
        do_write(kk, a, $urandom, 4'hF, 4'($urandom), 8'd0,
                 int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 0);
      end
    end
    for (int t = 0; t < 80; t++) begin
      k = int'($urandom_range(0, 1));
      a = pick_addr(($urandom_range(0, 5) == 0) ? 0 : 1);
      if ($urandom_range(0, 1) == 0)
        do_read(k, a, 4'($urandom), ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'd0,
                int'($urandom_range(0, 3)), rd);
      else
        do_write(k, a, $urandom, 4'($urandom_range(0, 15)), 4'($urandom),
                 ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'd0,
                 int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_23060025_axi_sram_slave.md
# ysyx_23060025_axi_sram_slave

AXI4 single-beat responder (the memory end of the core's AXI request/arbiter path) backing a word-addressed on-chip SRAM with programmable read/write latency. Independent read and write state machines accept one transaction each, echo the request ID, apply byte strobes, and return DECERR for out-of-window addresses. Used as the simulation/bring-up memory behind the core's AXI initiator and Xbar.

## Interface
- ADDR_LEN, 32, address width
- BASE_ADDR, 32'h8000_0000, window base; must be aligned to 2^(DEPTH_LOG2+2)
- DEPTH_LOG2, 10, log2 of SRAM depth in 32-bit words
- R_LATENCY, 2, wait cycles after AR handshake before rvalid (0..15)
- W_LATENCY, 2, wait cycles after AW+W captured before bvalid (0..15)
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- s_ar_addr_i  in  ADDR_LEN  read address
- s_ar_valid_i / s_ar_ready_o  in/out  1  AR handshake
- s_ar_id_i  in  4  read ID
- s_ar_len_i  in  8  burst length; only 0 supported
- s_r_data_o  out  32  read data
- s_r_resp_o  out  2  OKAY 00 / SLVERR 10 / DECERR 11
- s_r_valid_o / s_r_ready_i  out/in  1  R handshake
- s_r_last_o  out  1  always 1 when s_r_valid_o
- s_r_id_o  out  4  echoed ar_id
- s_aw_addr_i  in  ADDR_LEN  write address
- s_aw_valid_i / s_aw_ready_o  in/out  1  AW handshake
- s_aw_id_i  in  4  write ID
- s_aw_len_i  in  8  burst length; only 0 supported
- s_w_data_i  in  32  write data
- s_w_strb_i  in  4  byte enables
- s_w_valid_i / s_w_ready_o  in/out  1  W handshake
- s_b_resp_o  out  2  write response
- s_b_valid_o / s_b_ready_i  out/in  1  B handshake
- s_b_id_o  out  4  echoed aw_id

## Operation
- Decode: hit iff addr[ADDR_LEN-1:DEPTH_LOG2+2] == BASE_ADDR[same]; index = addr[DEPTH_LOG2+1:2]; addr[1:0] ignored. size/burst not ported (full word always).
- Read FSM R_IDLE -> R_WAIT -> R_RESP -> R_IDLE. R_IDLE: ar_ready=1; on handshake latch addr/id/len, load counter=R_LATENCY, go R_WAIT. R_WAIT: counter==0 -> sample SRAM into rdata register, go R_RESP; else decrement. R_RESP: r_valid=1, outputs stable until r_ready, then R_IDLE.
- Write FSM W_IDLE -> W_WAIT -> W_RESP -> W_IDLE. W_IDLE: aw_ready=1 until AW captured, w_ready=1 until W captured; either order or same cycle. Both captured -> counter=W_LATENCY, W_WAIT. W_WAIT counter==0 -> commit strobed bytes, go W_RESP. W_RESP: b_valid=1 held until b_ready.
- Resp: len!=0 -> SLVERR, no SRAM access, rdata=0; miss -> DECERR, rdata=0, write dropped; else OKAY. SLVERR takes priority over DECERR.
- Same-cycle read sample and write commit to one index: read returns old data.
- SRAM contents are not reset.

## Timing
- AR handshake at edge T -> r_valid high from edge T+1+R_LATENCY. Last of AW/W at T -> b_valid from T+1+W_LATENCY.
- No back-to-back: ar_ready (aw_ready/w_ready) reasserts the cycle after R (B) handshake; one outstanding per channel.
- Read and write FSMs fully independent; simultaneous AR and AW both accepted same cycle.
- While reset low: both FSMs IDLE, all readies 0, r_valid/b_valid 0, r_data 0, r_resp 0, r_last 0, r_id 0, b_resp 0, b_id 0, captured flags cleared. Readies go high at first rising edge after reset deasserts (registered flag). Reset mid-transaction aborts it; no response issued, pending write not committed.

## Test plan
- W 0x8000_0010 data 0xDEAD_BEEF strb 0xF, id 3 -> b_valid 3 cycles after handshake, b_resp 00, b_id 3; read same address id 5 -> r_data 0xDEAD_BEEF, r_resp 00, r_id 5, r_last 1, r_valid at T+3.
- Strobe merge: write 0x1122_3344 to 0x8000_0020 then strb 0x2 data 0x0000_AA00 -> read 0x1122_AA44.
- Read 0x1000_0000 -> r_resp 11, r_data 0; write there -> b_resp 11, SRAM unchanged; ar_len=3 -> r_resp 10, r_last 1.
- W before AW by 4 cycles, then AW; hold r_ready/b_ready low 5 cycles -> outputs stable, single response each, readies low until handshake.
- R_LATENCY=0, W_LATENCY=0 build: responses at T+1; simultaneous read/write same index -> read returns old value.
- Drop reset during R_WAIT and W_WAIT -> all outputs zero immediately; no r_valid/b_valid after release; target word unchanged.
